// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the pixel stream engine.
// Pixels are 4-bit R,G,B packed as {R,G,B}.
package pixel_stream_pkg;

  localparam int PIX_W = 12;

  typedef enum logic [1:0] {
    FUNC_INVERT   = 2'd0,
    FUNC_COLOR    = 2'd1,
    FUNC_CONTRAST = 2'd2,
    FUNC_THRESH   = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry synchronous FIFO holding ALU results until the write side accepts them.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module pix_fifo2
  import pixel_stream_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PIX_W-1:0] push_data,
  input  logic             pop,
  output logic [PIX_W-1:0] head,
  output logic [1:0]       count
);

  logic [1:0][PIX_W-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push_ok_s, pop_ok_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pop_ok_s  = pop && (cnt_q != 2'd0);
    push_ok_s = push && ((cnt_q != 2'd2) || pop_ok_s);
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
  end

  // FIFO state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/pixel_stream_engine.sv
// DMA-style engine: streams pixels from image memory through an external ALU
// and writes the results back in order, with write-side backpressure.
module pixel_stream_engine
  import pixel_stream_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        func,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  pix_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  alu_pixel,
  output logic [1:0]        alu_func,
  input  logic [PIX_W-1:0]  alu_result,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [PIX_W-1:0]  mem_wr_data,
  input  logic              mem_wr_ready
);

  state_e            state_q, state_d;
  func_e             func_q, func_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              inflight_q, inflight_d;
  logic              rd_en_s;
  logic              pop_s;
  logic [1:0]        fifo_cnt_s;
  logic [PIX_W-1:0]  fifo_head_s;
  logic [2:0]        credit_s;

  // Read data arrives one cycle after issue; the ALU result is captured on that edge.
  pix_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (alu_result),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_cnt_s)
  );

  assign pop_s    = (fifo_cnt_s != 2'd0) && mem_wr_ready;
  // Slots already claimed: buffered results plus a read whose data is still on its way.
  assign credit_s = {1'b0, fifo_cnt_s} + {2'b00, inflight_q} - {2'b00, pop_s};

  // Job sequencing, read issue and write counting.
  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    src_d    = src_q;
    dst_d    = dst_q;
    count_d  = count_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rd_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          func_d   = func_e'(func);
          src_d    = src_base;
          dst_d    = dst_base;
          count_d  = pix_count;
          rd_cnt_d = {CNT_W{1'b0}};
          wr_cnt_d = {CNT_W{1'b0}};
          state_d  = (pix_count == {CNT_W{1'b0}}) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rd_en_s = (rd_cnt_q < count_q) && (credit_s < 3'd2);
        if (rd_en_s) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
        if (pop_s) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          state_d  = (wr_cnt_q == count_q - CNT_W'(1)) ? DONE : RUN;
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    inflight_d = rd_en_s;
  end

  // Control and job-parameter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      func_q     <= FUNC_INVERT;
      src_q      <= {ADDR_W{1'b0}};
      dst_q      <= {ADDR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      rd_cnt_q   <= {CNT_W{1'b0}};
      wr_cnt_q   <= {CNT_W{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      count_q    <= count_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign mem_rd_en   = rd_en_s;
  assign mem_rd_addr = src_q + ADDR_W'(rd_cnt_q);
  assign alu_pixel   = mem_rd_data;
  assign alu_func    = func_q;
  assign mem_wr_en   = (fifo_cnt_s != 2'd0);
  assign mem_wr_addr = dst_q + ADDR_W'(wr_cnt_q);
  assign mem_wr_data = fifo_head_s;

endmodule

// File: tb/tb_pixel_stream_engine.sv
// Self-checking bench for pixel_stream_engine: memory and ALU models,
// directed and randomized jobs checked against a transaction-level reference.
module tb_pixel_stream_engine;
  import pixel_stream_pkg::*;

  localparam int AW = 17;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    func;
  logic [AW-1:0] src_base, dst_base;
  logic [CW-1:0] pix_count;
  logic          busy, done, mem_rd_en, mem_wr_en, mem_wr_ready;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [11:0]   mem_rd_data, alu_pixel, alu_result, mem_wr_data;
  logic [1:0]    alu_func;

  pixel_stream_engine #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func),
    .src_base(src_base), .dst_base(dst_base), .pix_count(pix_count),
    .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .alu_pixel(alu_pixel), .alu_func(alu_func), .alu_result(alu_result),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready)
  );

  always #5 clk = ~clk;

  logic [11:0]  img [0:(1<<AW)-1];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           s0 = 0;
  int           rel;
  logic [511:0] ready_vec = '1;
  logic [1:0]   exp_func = 2'd0;

  assign rel          = cyc - s0;
  assign mem_wr_ready = (rel >= 0 && rel < 512) ? ready_vec[rel] : 1'b1;

  function automatic logic [3:0] sat2(input logic [3:0] c);
    return (c >= 4'd8) ? 4'hF : {c[2:0], 1'b0};
  endfunction

  // Bench-owned ALU: any deterministic pixel function will do.
  function automatic logic [11:0] alu_model(input logic [1:0] f, input logic [11:0] p);
    logic [3:0] r, g, b;
    r = p[11:8]; g = p[7:4]; b = p[3:0];
    case (f)
      2'd0:    return ~p;
      2'd1:    return {g, b, r};
      2'd2:    return {sat2(r), sat2(g), sat2(b)};
      default: return ((int'(r) + int'(g) + int'(b)) >= 24) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  assign alu_result = alu_model(alu_func, alu_pixel);

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records transactions (tagged with cycle relative to the start cycle).
  int            rd_tag[$];
  logic [AW-1:0] rd_adr[$];
  int            wr_tag[$];
  logic [AW-1:0] wr_adr[$];
  logic [11:0]   wr_dat[$];
  int            done_tag[$];
  int            busy_n = 0, func_viol = 0, stab_viol = 0, outst = 0, outst_max = 0;
  int            o_next;
  logic          stall_prev = 1'b0;
  logic [AW-1:0] stall_adr = '0;
  logic [11:0]   stall_dat = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr_l = '0;

  assign o_next = outst + (mem_rd_en ? 1 : 0) - ((mem_wr_en && mem_wr_ready) ? 1 : 0);

  always @(negedge clk) begin
    rd_req    <= mem_rd_en;
    rd_addr_l <= mem_rd_addr;
    if (mem_rd_en) begin rd_tag.push_back(rel); rd_adr.push_back(mem_rd_addr); end
    if (mem_wr_en && mem_wr_ready) begin
      wr_tag.push_back(rel); wr_adr.push_back(mem_wr_addr); wr_dat.push_back(mem_wr_data);
    end
    if (done) done_tag.push_back(rel);
    if (busy) busy_n <= busy_n + 1;
    if (busy && alu_func !== exp_func) func_viol <= func_viol + 1;
    if (!rst && stall_prev && (!mem_wr_en || mem_wr_addr !== stall_adr || mem_wr_data !== stall_dat))
      stab_viol <= stab_viol + 1;
    stall_prev <= mem_wr_en && !mem_wr_ready;
    stall_adr  <= mem_wr_addr;
    stall_dat  <= mem_wr_data;
    outst      <= rst ? 0 : o_next;
    if (o_next > outst_max) outst_max <= o_next;
  end

  // Synchronous memory: data one cycle after the request, garbage otherwise.
  always @(posedge clk) mem_rd_data <= rd_req ? img[rd_addr_l] : 12'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string nm, input logic [1:0] f, input logic [AW-1:0] src,
                         input logic [AW-1:0] dst, input int n, input int mode,
                         input bit keep_mem, input bit toggle,
                         output int rb, output int wb, output int dn);
    int db, bb, fb, sb, lastw;
    logic [11:0] expd[$];
    if (!keep_mem) for (int i = 0; i < n; i++) img[AW'(src + i)] = 12'($urandom);
    for (int i = 0; i < n; i++) expd.push_back(alu_model(f, img[AW'(src + i)]));
    ready_vec = '1;
    if (mode == 1) for (int k = 4; k <= 8; k++) ready_vec[k] = 1'b0;
    if (mode == 2) for (int k = 0; k < 300; k++) ready_vec[k] = ($urandom_range(0, 9) < 7);
    rb = rd_tag.size(); wb = wr_tag.size(); db = done_tag.size();
    bb = busy_n; fb = func_viol; sb = stab_viol;
    exp_func = f;
    @(posedge clk); #1;
    s0 = cyc; start = 1'b1; func = f; src_base = src; dst_base = dst; pix_count = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (toggle) begin
      for (int k = 0; k < 4; k++) begin
        start = 1'($urandom); func = 2'd3; src_base = AW'($urandom); dst_base = AW'($urandom);
        pix_count = CW'($urandom_range(1, 50));
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    for (int c = 0; c < 3000 && done_tag.size() == db; c++) begin @(posedge clk); #1; end
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_done_cnt"}, done_tag.size() - db, 1);
    dn = (done_tag.size() > db) ? done_tag[db] : -99;
    chk({nm, "_rd_cnt"}, rd_tag.size() - rb, n);
    chk({nm, "_wr_cnt"}, wr_tag.size() - wb, n);
    for (int i = 0; i < n; i++) begin
      if (rb + i < rd_tag.size()) begin
        chk({nm, "_rd_addr"}, rd_adr[rb + i], AW'(src + i));
        if (mode == 0) chk({nm, "_rd_cyc"}, rd_tag[rb + i], i + 1);
      end
      if (wb + i < wr_tag.size()) begin
        chk({nm, "_wr_addr"}, wr_adr[wb + i], AW'(dst + i));
        chk({nm, "_wr_data"}, wr_dat[wb + i], expd[i]);
      end
    end
    lastw = (wr_tag.size() > wb) ? wr_tag[wr_tag.size() - 1] : -99;
    if (n > 0) begin
      chk({nm, "_done_after_last"}, dn, lastw + 1);
      chk({nm, "_busy_cycles"}, busy_n - bb, dn - 1);
    end else begin
      chk({nm, "_done_cyc"}, dn, 1);
      chk({nm, "_busy_cycles"}, busy_n - bb, 0);
    end
    if (mode == 0 && n > 0) begin
      chk({nm, "_first_wr"}, (wr_tag.size() > wb) ? wr_tag[wb] : -99, 3);
      chk({nm, "_last_wr"}, lastw, n + 2);
      chk({nm, "_done_cyc"}, dn, n + 3);
    end
    chk({nm, "_func_hold"}, func_viol - fb, 0);
    chk({nm, "_wr_stable"}, stab_viol - sb, 0);
    chk({nm, "_credit"}, (outst_max <= 2) ? 1 : 0, 1);
    chk({nm, "_func_idle"}, alu_func, f);
  endtask

  initial begin
    int rb, wb, dn, db;
    rst = 1'b1; start = 1'b0; func = 2'd0; src_base = '0; dst_base = '0; pix_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_alu_func", alu_func, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    rst = 1'b0;

    img[17'h100] = 12'h123; img[17'h101] = 12'h456; img[17'h102] = 12'h789; img[17'h103] = 12'hABC;
    run_job("basic", 2'd0, 17'h00100, 17'h00200, 4, 0, 1'b1, 1'b0, rb, wb, dn);
    chk("basic_d0", wr_dat[wb], 12'hEDC);
    chk("basic_d1", wr_dat[wb + 1], 12'hBA9);
    chk("basic_d2", wr_dat[wb + 2], 12'h876);
    chk("basic_d3", wr_dat[wb + 3], 12'h543);

    run_job("stall", 2'd0, 17'h00100, 17'h00200, 4, 1, 1'b1, 1'b0, rb, wb, dn);
    chk("stall_rd3_cyc", rd_tag[rb + 3], 9);
    chk("stall_wr1_cyc", wr_tag[wb + 1], 9);
    chk("stall_wr3_cyc", wr_tag[wb + 3], 11);
    chk("stall_done_cyc", dn, 12);

    run_job("zero", 2'd1, 17'h00010, 17'h00020, 0, 0, 1'b0, 1'b0, rb, wb, dn);

    run_job("wrap", 2'd1, 17'h1FFFE, 17'h1FFFF, 3, 0, 1'b0, 1'b0, rb, wb, dn);
    chk("wrap_rd2", rd_adr[rb + 2], 17'h00000);
    chk("wrap_wr1", wr_adr[wb + 1], 17'h00000);
    chk("wrap_wr2", wr_adr[wb + 2], 17'h00001);

    // Abort a job after two reads.
    exp_func = 2'd1; ready_vec = '1;
    @(posedge clk); #1;
    s0 = cyc; start = 1'b1; func = 2'd1; src_base = 17'h00300; dst_base = 17'h00400; pix_count = 17'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_wr_en", mem_wr_en, 0);
    chk("abort_done", done, 0);
    chk("abort_alu_func", alu_func, 0);
    rb = rd_tag.size(); wb = wr_tag.size(); db = done_tag.size();
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_rd", rd_tag.size() - rb, 0);
    chk("abort_no_wr", wr_tag.size() - wb, 0);
    chk("abort_no_done", done_tag.size() - db, 0);
    run_job("after_abort", 2'd2, 17'h00500, 17'h00600, 2, 0, 1'b0, 1'b0, rb, wb, dn);

    run_job("toggle", 2'd2, 17'h00700, 17'h00800, 6, 0, 1'b0, 1'b1, rb, wb, dn);

    for (int j = 0; j < 6; j++) begin
      logic [AW-1:0] rs, rd;
      rs = (j % 2 == 0) ? AW'(17'h1FFF0 + $urandom_range(0, 15)) : AW'($urandom);
      rd = AW'($urandom);
      run_job("rand", 2'($urandom), rs, rd, $urandom_range(1, 20), 2, 1'b0, 1'b0, rb, wb, dn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_stream_engine.md
Name: pixel_stream_engine

Overview:
- Coprocessor DMA-style engine that feeds the combinational pixel ALU and writes its results back.
- On start it streams pix_count 12-bit pixels from image memory at src_base and presents each to the ALU with a latched opcode.
- It captures each ALU result and writes it to image memory at dst_base, preserving order, with backpressure on the write side.
- The ALU is external; this block drives its inputs and consumes its output.

Parameters:
- ADDR_W, 17: image memory word-address width (320x240 = 76800 pixels fits).
- CNT_W, 17: pixel-count width.
- PIX_W, 12: pixel width as 4-bit R,G,B. Fixed; not to be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a job; sampled only in IDLE.
- func  in  2  ALU opcode: 0 invert, 1 color, 2 contrast, 3 thresh.
- src_base  in  ADDR_W  first source pixel address.
- dst_base  in  ADDR_W  first destination pixel address.
- pix_count  in  CNT_W  number of pixels to process.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last write has been accepted.
- mem_rd_en  out  1  read request; data returns exactly 1 cycle later.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  PIX_W  read data, valid the cycle after mem_rd_en.
- alu_pixel  out  PIX_W  ALU operand; combinational copy of mem_rd_data.
- alu_func  out  2  latched opcode.
- alu_result  in  PIX_W  ALU output, combinational from alu_pixel.
- mem_wr_en  out  1  write valid.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  PIX_W  write data.
- mem_wr_ready  in  1  memory accepts the write this cycle.

Behaviour:
- Reset: state IDLE. busy, done, mem_rd_en, mem_wr_en, all address/data/alu_func registers = 0. FIFO emptied. Any in-flight read is discarded.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 latches func, src_base, dst_base, pix_count, and clears rd_cnt and wr_cnt.
    - pix_count=0: go to DONE.
    - otherwise: go to RUN.
  - RUN: exits to DONE in the cycle where the write with wr_cnt = count-1 is accepted.
  - DONE: done=1, busy=0 for one cycle, then IDLE.
- start is ignored outside IDLE. Input changes after start are ignored.
- Read issue (RUN): mem_rd_en = (rd_cnt < count) && (fifo_cnt + inflight - pop < 2).
  - inflight = registered mem_rd_en.
  - pop = mem_wr_en && mem_wr_ready.
  - The combinational path mem_wr_ready -> mem_rd_en is permitted.
- mem_rd_addr = src_base + rd_cnt, modulo 2^ADDR_W (wraps).
- Data path: in the cycle after a read, alu_pixel = mem_rd_data and alu_result is pushed into a 2-entry FIFO at the clock edge. The FIFO never overflows, by credit.
- Write side: mem_wr_en = FIFO nonempty. mem_wr_data = FIFO head. mem_wr_addr = dst_base + wr_cnt, modulo 2^ADDR_W.
  - A transfer occurs only when mem_wr_en && mem_wr_ready.
  - mem_wr_data and mem_wr_addr stay stable while mem_wr_ready is low.
- Simultaneous push and pop keeps fifo_cnt unchanged.
- Timing with ready=1:
  - start at cycle 0; first mem_rd_en at cycle 1.
  - first mem_wr_en at cycle 3.
  - 1 pixel/cycle throughput; last write at cycle N+2; done at cycle N+3.
- alu_func is held at the latched value while busy and retains it in IDLE.
- rst asserted mid-job: takes effect at the next edge. No further rd/wr strobes, and no done pulse for the aborted job.

Decomposition:
- Package pixel_stream_pkg contains:
  - func enum: FUNC_INVERT=0, FUNC_COLOR=1, FUNC_CONTRAST=2, FUNC_THRESH=3.
  - state enum: IDLE, RUN, DONE.
  - PIX_W=12.
- Sub-module pix_fifo2: 2-entry synchronous FIFO with push, pop, head, and count[1:0]. Synchronous active-high reset.

Test Plan:
- N=4, src=0x00100, dst=0x00200, func=0, mem holds 0x123,0x456,0x789,0xABC, ready=1 -> reads at 0x100..0x103 in cycles 1-4; writes 0xEDC,0xBA9,0x876,0x543 to 0x200..0x203 in cycles 3-6; done in cycle 7.
- Same job with mem_wr_ready=0 for cycles 4-8 -> at most 2 pixels buffered; mem_rd_en low while credit is exhausted; write 2 held stable; all 4 writes in order; done the cycle after the last accept.
- pix_count=0, start at cycle 0 -> done=1 in cycle 1; no mem_rd_en or mem_wr_en ever asserted.
- src_base=0x1FFFE, dst_base=0x1FFFF, N=3 -> read addrs 0x1FFFE, 0x1FFFF, 0x00000; write addrs 0x1FFFF, 0x00000, 0x00001.
- rst pulsed during RUN after 2 reads -> next cycle busy=0, all strobes 0, no done. A following start with N=2 completes normally.
- start and func=3 toggled while busy in a func=2 job -> ignored; alu_func stays 2 for the whole job; exactly one done pulse.
